// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit async SRAM: two half-word phases (low, high) of WAIT_CYCLES each, then one DONE cycle.
// Define SRAM_ADDR_OFFSET_EN to subtract the 1024-byte data region base from the incoming address.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_op_q, wr_op_d;
    logic [16:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic        req;
    logic        phase_last;
    logic        in_phase_d;
    logic [16:0] req_idx;
    logic        unused_addr_bits;

    assign req = rd_en | wr_en;

    // Only bits [18:2] of the physical byte address reach the SRAM; a 1024-byte
    // offset is exactly 256 words, so it can be removed on the word index alone.
`ifdef SRAM_ADDR_OFFSET_EN
    assign req_idx = address[18:2] - 17'd256;
`else
    assign req_idx = address[18:2];
`endif
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_op_d    = wr_op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        phase_last = (cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = 3'd0;
                    wr_op_d = wr_en;
                    idx_d   = req_idx;
                    wdata_d = write_data;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_d = HIGH;
                    cnt_d   = 3'd0;
                    if (!wr_op_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    if (!wr_op_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // Strobes are registered from the next state so they line up with the phase cycles.
        in_phase_d = (state_d == LOW) || (state_d == HIGH);
        we_n_d     = !(in_phase_d && wr_op_d && (cnt_d != LAST_CNT));
        oe_n_d     = !(in_phase_d && !wr_op_d);
        dq_oe_d    = in_phase_d && wr_op_d;
        dq_out_d   = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
        addr_d     = addr_q;
        if (in_phase_d) addr_d = {idx_d, state_d == HIGH};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            wr_op_q  <= 1'b0;
            idx_q    <= 17'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            addr_q   <= 18'd0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_op_q  <= wr_op_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    // Idle ready must drop in the same cycle a request appears so the pipeline freezes at once.
    assign ready     = (state_q == IDLE) ? !req : (state_q == DONE);
    assign read_data = rdata_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Randomised scoreboard bench for sram_controller: word-level reference memory, per-cycle bus checks, plus a WAIT_CYCLES=1 instance.
module tb_sram_controller;

    localparam int W = 2;
`ifdef SRAM_ADDR_OFFSET_EN
    localparam logic [31:0] OFF = 32'd1024;
`else
    localparam logic [31:0] OFF = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    logic        rd1 = 1'b0;
    logic [31:0] address1 = '0;
    logic [31:0] read_data1;
    logic        ready1;
    wire  [15:0] sram_dq1;
    logic [17:0] sram_addr1;
    logic        we1_n, oe1_n, ce1_n, ub1_n, lb1_n;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
        .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
        .SRAM_LB_N(sram_lb_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd1), .address(address1),
        .write_data(32'd0), .read_data(read_data1), .ready(ready1),
        .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we1_n),
        .SRAM_OE_N(oe1_n), .SRAM_CE_N(ce1_n), .SRAM_UB_N(ub1_n),
        .SRAM_LB_N(lb1_n)
    );

    // External SRAM model: 64 half-words, written on any clock edge where WE_N is low.
    logic [15:0] mem_arr [0:63];
    logic        mem_load = 1'b1;

    function automatic logic [15:0] init_hw(input int i);
        if (i == 2) return 16'h5678;
        if (i == 3) return 16'h1234;
        return 16'h3C00 + 16'(i * 16'h0101);
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem_arr[i] = init_hw(i);
        end else if (!sram_we_n) begin
            mem_arr[sram_addr[5:0]] = sram_dq;
        end
    end

    assign sram_dq  = sram_oe_n ? 16'hzzzz : mem_arr[sram_addr[5:0]];
    assign sram_dq1 = oe1_n ? 16'hzzzz : (sram_addr1[15:0] ^ 16'hA5A5);

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_word [0:31];
    logic [31:0] last_rd = 32'd0;
    logic [31:0] sb_q [$];
    bit          mon_en = 1'b0;
    int          lo_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each low-to-high ready transition ends one transaction.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!ready) begin
                lo_cnt++;
            end else if (lo_cnt != 0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    chk("latency_ready_low", 32'(lo_cnt), 32'(2 * W + 1));
                    chk("read_data", read_data, e);
                end
                lo_cnt = 0;
            end
        end
    end

    // Issue one transaction starting just after a rising edge; returns just after the edge ending DONE.
    task automatic txn(input bit w, input bit r, input int idx, input logic [31:0] d);
        logic [31:0] a;
        logic [31:0] exp_rd;
        int          c;
        bit          hi;
        int          pos;
        a = OFF + 32'(idx << 2) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 1)) << 20);
        wr_en = w; rd_en = r; address = a; write_data = d;
        if (w) begin
            ref_word[idx] = d;
            exp_rd = last_rd;
        end else begin
            exp_rd = ref_word[idx];
            last_rd = exp_rd;
        end
        sb_q.push_back(exp_rd);
        @(negedge clk);
        c = 0;
        do begin
            @(posedge clk); #1;
            address = $urandom;
            write_data = $urandom;
            @(negedge clk);
            c++;
            if (c <= 2 * W) begin
                hi  = (c > W);
                pos = hi ? c - W : c;
                chk("sram_addr", 32'(sram_addr), 32'({idx[16:0], hi}));
                if (w) begin
                    chk("we_n", 32'(sram_we_n), 32'(pos == W));
                    chk("oe_n_on_write", 32'(sram_oe_n), 32'd1);
                    chk("dq_write", 32'(sram_dq), 32'(hi ? d[31:16] : d[15:0]));
                end else begin
                    chk("oe_n_on_read", 32'(sram_oe_n), 32'd0);
                    chk("we_n_on_read", 32'(sram_we_n), 32'd1);
                end
            end
        end while (!ready && c < 40);
        if (!ready) chk("txn_timeout", 32'(ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) ref_word[k] = {init_hw(2 * k + 1), init_hw(2 * k)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("strobes_low", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_load = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Known-content read of half-words 2 and 3, then hold.
        txn(1'b0, 1'b1, 1, 32'd0);
        idle(0);
        repeat (3) begin
            @(negedge clk);
            chk("read_data_hold", read_data, 32'h12345678);
        end
        @(posedge clk); #1;

        txn(1'b1, 1'b0, 0, 32'hDEADBEEF);
        idle(2);
        txn(1'b0, 1'b1, 0, 32'd0);
        idle(1);
        txn(1'b1, 1'b1, 5, 32'hCAFEF00D);
        idle(1);
        txn(1'b0, 1'b1, 5, 32'd0);
        // Back-to-back loads with rd_en held high.
        txn(1'b0, 1'b1, 7, 32'd0);
        txn(1'b0, 1'b1, 9, 32'd0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            txn(kind != 1 && kind != 3, kind != 0, $urandom_range(0, 31), $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(1);

        // Abort a load in its second HIGH cycle.
        txn(1'b0, 1'b1, 2, 32'd0);
        mon_en = 1'b0;
        rd_en = 1'b1;
        address = OFF + 32'(3 << 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_high_addr", 32'(sram_addr), 32'({17'd3, 1'b1}));
        @(posedge clk); #1;
        rst = 1'b1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_ready", 32'(ready), 32'd1);
        chk("post_abort_read_data", read_data, 32'd0);
        lo_cnt = 0;
        last_rd = 32'd0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 4, 32'h0F1E2D3C);
        idle(1);
        txn(1'b0, 1'b1, 4, 32'd0);
        idle(2);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // WAIT_CYCLES=1 instance: byte address 8 -> half-words 4 and 5.
        rd1 = 1'b1;
        address1 = OFF + 32'd8;
        @(negedge clk);
        chk("w1_req_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_low_addr", 32'(sram_addr1), 32'd4);
        chk("w1_low_oe_n", 32'(oe1_n), 32'd0);
        chk("w1_low_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_high_addr", 32'(sram_addr1), 32'd5);
        chk("w1_high_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_done_ready", 32'(ready1), 32'd1);
        chk("w1_read_data", read_data1, {16'h0005 ^ 16'hA5A5, 16'h0004 ^ 16'hA5A5});
        rd1 = 1'b0;
        @(negedge clk);
        chk("w1_idle_ready", 32'(ready1), 32'd1);
        chk("w1_idle_oe_n", 32'(oe1_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
